dmem_unit: RTL and testbench
============================

# dmem_unit

Data-memory stage of the five-stage RV32I pipeline. It consumes the MEM-stage controls and operands (MemRead, MemWrite, funct3, ALU-computed address, store data) and produces load data for the WB stage. It holds a word-organised synchronous RAM with byte lanes. It performs RV32I byte, halfword and word store merging and load extension. It detects misaligned, out-of-range and illegal-width accesses, suppresses them, and records the first fault.

## Interface
Parameters:
- data_size, 1024, RAM depth in 32-bit words (power of two).
- address_size, 32, data/address width.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET_N  in  1  reset; asynchronous and active-low.
- MemRead  in  1  load request from the MEM stage.
- MemWrite  in  1  store request from the MEM stage.
- funct3  in  3  access width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- daddr  in  address_size  byte address.
- ddata_w  in  address_size  store data; the lower byte or halfword is used for sb and sh.
- err_clr  in  1  clears the sticky fault state.
- ddata_r  out  address_size  extended load data, valid in the cycle after the load edge.
- fault  out  1  one-cycle pulse in the cycle after a rejected access.
- err_sticky  out  1  set by the first fault; held until err_clr or reset.
- err_addr  out  address_size  daddr of the first fault since the last clear.
- err_cause  out  2  01 misaligned, 10 out-of-range, 11 illegal funct3.

## Operation
- Word index = daddr[$clog2(data_size)+1:2]; byte offset = daddr[1:0].
- Access request = MemRead | MemWrite. If both are high, the access is a store and the read is ignored.
- Fault checks are evaluated combinationally, in priority order:
  - Illegal funct3: loads accept only 000, 001, 010, 100, 101; stores accept only 000, 001, 010.
  - Misaligned: a halfword access with daddr[0]=1, or a word access with daddr[1:0]≠00.
  - Out-of-range: daddr ≥ 4*data_size.
- A faulting access performs no RAM write and no ddata_r update.
- Store (no fault) updates only the addressed lanes:
  - sb writes byte lane daddr[1:0] with ddata_w[7:0].
  - sh writes lanes {daddr[1],0} and {daddr[1],1} with ddata_w[15:0].
  - sw writes all four lanes.
- Load (no fault):
  - At the edge, register the RAM word, funct3 and offset.
  - ddata_r is formed from the registered word: lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word.
- ddata_r holds its last value when no load occurs.
- Fault capture:
  - On a fault edge, fault=1 for exactly the next cycle.
  - If err_sticky=0: set err_sticky=1 and latch err_addr and err_cause.
  - If err_sticky=1: keep the first record; fault still pulses.
- err_clr: on the edge, clears err_sticky, err_addr and err_cause. If a fault occurs on the same edge, the new fault is recorded, because capture takes priority over clear.
- RAM contents are not initialised by reset and are undefined until written.

## Timing
- Reset values: ddata_r=0, fault=0, err_sticky=0, err_addr=0, err_cause=00. The internal load-format register (funct3, offset) resets to 000/00.
- Store latency: RAM is updated at the rising edge where MemWrite=1. A load at the same address on the next edge returns the new data.
- Load latency: 1 cycle. Request at edge N; ddata_r is valid from edge N until edge N+1.
- Back-to-back loads: accepted every cycle; each result appears one cycle after its edge.
- A store followed by a load to the same word on consecutive edges returns the stored data. There is no bypass requirement within the same edge, because a store blocks the read.
- A reset assertion mid-access aborts it. An in-flight store edge that coincides with reset assertion does not occur, since reset is asynchronous and dominates. Outputs go to reset values immediately.
- No stall output: every non-faulting access completes in one cycle.

## Test plan
- **Reset:** hold RESET_N=0 for 2 cycles, then release. Required: ddata_r=0, fault=0, err_sticky=0, err_addr=0, err_cause=00.
- **Byte lanes:**
  - sw 0x11223344 to 0x10.
  - sb 0xAB to 0x11.
  - lw 0x10 → 0x1122AB44.
  - lb 0x11 → 0xFFFFFFAB; lbu 0x11 → 0x000000AB.
- **Halfword:**
  - sh 0x8001 to 0x22.
  - lh 0x22 → 0xFFFF8001; lhu 0x22 → 0x00008001.
  - lw 0x20 → upper half 0x8001, lower half unchanged.
- **Misaligned:**
  - sw 0xDEADBEEF to 0x06. Required: fault pulses for 1 cycle, err_sticky=1, err_addr=0x06, err_cause=01; RAM word at index 1 is unchanged.
  - Then lh at 0x33. Required: fault pulses again; err_addr stays 0x06.
- **Out-of-range and clear:**
  - lw at 0x1000 with data_size=1024. Required: err_cause=10 and ddata_r unchanged.
  - err_clr alone. Required: err_sticky=0.
  - err_clr together with a store of funct3=011. Required: err_sticky=1, err_cause=11.
- **Simultaneous and back-to-back:**
  - MemRead=MemWrite=1, sw 0x55 to 0x40. Required: ddata_r holds its previous value.
  - Next-cycle lw 0x40 → 0x00000055.
  - Three consecutive loads of distinct words. Required: each value appears exactly one cycle after its request.

Source files
------------

// File: rtl/dmem_unit.sv
// Data-memory stage: byte-lane word RAM with RV32I store merging, load extension
// and first-fault capture for misaligned, out-of-range and illegal-width accesses.
module dmem_unit #(
    parameter int unsigned data_size    = 1024,
    parameter int unsigned address_size = 32
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [2:0]              funct3,
    input  logic [address_size-1:0] daddr,
    input  logic [address_size-1:0] ddata_w,
    input  logic                    err_clr,
    output logic [address_size-1:0] ddata_r,
    output logic                    fault,
    output logic                    err_sticky,
    output logic [address_size-1:0] err_addr,
    output logic [1:0]              err_cause
);

    localparam int unsigned IDX_W  = $clog2(data_size);
    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_MIS  = 2'b01;
    localparam logic [1:0] CAUSE_OOR  = 2'b10;
    localparam logic [1:0] CAUSE_ILL  = 2'b11;

    logic [WORD_W-1:0] mem [data_size];

    logic              req_c;
    logic              illegal_c;
    logic              misalign_c;
    logic              oor_c;
    logic [1:0]        cause_c;
    logic              flt_c;
    logic              wr_en_c;
    logic              rd_en_c;
    logic [3:0]        be_c;
    logic [WORD_W-1:0] wdata_c;
    logic [IDX_W-1:0]  idx_c;

    logic [WORD_W-1:0] rd_word;
    logic [2:0]        ld_f3;
    logic [1:0]        ld_off;

    // Access classification and fault priority: illegal width, then alignment, then range.
    always_comb begin
        req_c      = MemRead | MemWrite;
        illegal_c  = MemWrite ? (funct3[2] || (funct3[1:0] == 2'b11))
                              : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
        misalign_c = ((funct3[1:0] == 2'b01) && daddr[0]) ||
                     ((funct3[1:0] == 2'b10) && (daddr[1:0] != 2'b00));
        oor_c      = (daddr[address_size-1:IDX_W+2] != '0);
        if (illegal_c)       cause_c = CAUSE_ILL;
        else if (misalign_c) cause_c = CAUSE_MIS;
        else if (oor_c)      cause_c = CAUSE_OOR;
        else                 cause_c = CAUSE_NONE;
        flt_c   = req_c && (cause_c != CAUSE_NONE);
        wr_en_c = MemWrite && !flt_c;
        rd_en_c = MemRead && !MemWrite && !flt_c;
        idx_c   = daddr[IDX_W+1:2];
    end

    // Lane enables and lane-replicated write data for sb/sh/sw.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = ddata_w[WORD_W-1:0];
        case (funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << daddr[1:0];
                wdata_c = {4{ddata_w[7:0]}};
            end
            2'b01: begin
                be_c    = daddr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{ddata_w[15:0]}};
            end
            default: ;
        endcase
    end

    // RAM array is intentionally not reset.
    always_ff @(posedge CLK) begin
        if (wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) mem[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_word <= '0;
            ld_f3   <= 3'b000;
            ld_off  <= 2'b00;
        end else if (rd_en_c) begin
            rd_word <= mem[idx_c];
            ld_f3   <= funct3;
            ld_off  <= daddr[1:0];
        end
    end

    // Load extraction and sign/zero extension from the registered word.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        case (ld_off)
            2'b00:   lane_b = rd_word[7:0];
            2'b01:   lane_b = rd_word[15:8];
            2'b10:   lane_b = rd_word[23:16];
            default: lane_b = rd_word[31:24];
        endcase
        lane_h = ld_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (ld_f3)
            3'b000:  ddata_r = {{24{lane_b[7]}}, lane_b};
            3'b001:  ddata_r = {{16{lane_h[15]}}, lane_h};
            3'b100:  ddata_r = {24'h0, lane_b};
            3'b101:  ddata_r = {16'h0, lane_h};
            default: ddata_r = rd_word;
        endcase
    end

    // Fault pulse and sticky first-fault record; a new fault outranks a clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fault      <= 1'b0;
            err_sticky <= 1'b0;
            err_addr   <= '0;
            err_cause  <= CAUSE_NONE;
        end else begin
            fault <= flt_c;
            if (flt_c && (!err_sticky || err_clr)) begin
                err_sticky <= 1'b1;
                err_addr   <= daddr;
                err_cause  <= cause_c;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
                err_addr   <= '0;
                err_cause  <= CAUSE_NONE;
            end
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: byte-level memory model compared every
// cycle, plus directed vectors with literal expectations.
module tb_dmem_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] daddr;
    logic [31:0] ddata_w;
    logic        err_clr;
    logic [31:0] ddata_r;
    logic        fault;
    logic        err_sticky;
    logic [31:0] err_addr;
    logic [1:0]  err_cause;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    always #5 CLK = ~CLK;

    dmem_unit #(.data_size(1024), .address_size(32)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .daddr(daddr), .ddata_w(ddata_w), .err_clr(err_clr),
        .ddata_r(ddata_r), .fault(fault), .err_sticky(err_sticky),
        .err_addr(err_addr), .err_cause(err_cause)
    );

    // Behavioural model: byte-addressed memory, outputs derived from access rules.
    logic [7:0]  mb [0:4095];
    logic [31:0] m_ddata;
    logic        m_fault;
    logic        m_sticky;
    logic [31:0] m_eaddr;
    logic [1:0]  m_ecause;

    always @(posedge CLK or negedge RESET_N) begin
        bit          req;
        bit          legal;
        bit          mis;
        bit          oor;
        int          sz;
        int          a;
        logic [1:0]  cause;
        logic [31:0] v;
        if (!RESET_N) begin
            m_ddata  = 32'h0;
            m_fault  = 1'b0;
            m_sticky = 1'b0;
            m_eaddr  = 32'h0;
            m_ecause = 2'b00;
        end else begin
            req = MemRead || MemWrite;
            if (MemWrite) legal = funct3 inside {3'b000, 3'b001, 3'b010};
            else          legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            sz  = 1 << funct3[1:0];
            mis = (daddr % sz) != 0;
            oor = daddr >= 32'd4096;
            if (!legal)   cause = 2'd3;
            else if (mis) cause = 2'd1;
            else if (oor) cause = 2'd2;
            else          cause = 2'd0;
            m_fault = req && (cause != 2'd0);
            if (m_fault && (!m_sticky || err_clr)) begin
                m_sticky = 1'b1;
                m_eaddr  = daddr;
                m_ecause = cause;
            end else if (err_clr) begin
                m_sticky = 1'b0;
                m_eaddr  = 32'h0;
                m_ecause = 2'b00;
            end
            if (req && !m_fault) begin
                a = int'(daddr);
                if (MemWrite) begin
                    for (int i = 0; i < sz; i++) mb[a+i] = ddata_w[8*i +: 8];
                end else begin
                    v = 32'h0;
                    for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[a+i];
                    if (!funct3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
                    if (!funct3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
                    m_ddata = v;
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge CLK) begin
        if (check_en) begin
            cmp("ddata_r",    ddata_r,             m_ddata);
            cmp("fault",      32'(fault),          32'(m_fault));
            cmp("err_sticky", 32'(err_sticky),     32'(m_sticky));
            cmp("err_addr",   err_addr,            m_eaddr);
            cmp("err_cause",  32'(err_cause),      32'(m_ecause));
        end
    end

    task automatic acc(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input bit clr);
        MemRead  = rd;
        MemWrite = wr;
        funct3   = f3;
        daddr    = a;
        ddata_w  = d;
        err_clr  = clr;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        funct3   = 3'b000;
        daddr    = 32'h0;
        ddata_w  = 32'h0;
        err_clr  = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp(nm, act, exp);
    endtask

    initial begin
        RESET_N  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        funct3   = 3'b000;
        daddr    = 32'h0;
        ddata_w  = 32'h0;
        err_clr  = 1'b0;
        @(posedge CLK);
        check_en = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        lit("rst_ddata_r",   ddata_r,            32'h0);
        lit("rst_fault",     32'(fault),         32'h0);
        lit("rst_sticky",    32'(err_sticky),    32'h0);
        lit("rst_err_addr",  err_addr,           32'h0);
        lit("rst_err_cause", 32'(err_cause),     32'h0);
        RESET_N = 1'b1;

        // Byte lanes
        acc(0, 1, 3'b010, 32'h10, 32'h11223344, 0);
        acc(0, 1, 3'b000, 32'h11, 32'h000000AB, 0);
        acc(1, 0, 3'b010, 32'h10, 32'h0, 0);
        lit("lw_0x10", ddata_r, 32'h1122AB44);
        acc(1, 0, 3'b000, 32'h11, 32'h0, 0);
        lit("lb_0x11", ddata_r, 32'hFFFFFFAB);
        acc(1, 0, 3'b100, 32'h11, 32'h0, 0);
        lit("lbu_0x11", ddata_r, 32'h000000AB);

        // Halfword
        acc(0, 1, 3'b010, 32'h20, 32'hCAFE1234, 0);
        acc(0, 1, 3'b001, 32'h22, 32'h00008001, 0);
        acc(1, 0, 3'b001, 32'h22, 32'h0, 0);
        lit("lh_0x22", ddata_r, 32'hFFFF8001);
        acc(1, 0, 3'b101, 32'h22, 32'h0, 0);
        lit("lhu_0x22", ddata_r, 32'h00008001);
        acc(1, 0, 3'b010, 32'h20, 32'h0, 0);
        lit("lw_0x20", ddata_r, 32'h80011234);

        // Misaligned
        acc(0, 1, 3'b010, 32'h04, 32'h0BADF00D, 0);
        acc(0, 1, 3'b010, 32'h06, 32'hDEADBEEF, 0);
        lit("mis_fault",  32'(fault),      32'h1);
        lit("mis_sticky", 32'(err_sticky), 32'h1);
        lit("mis_addr",   err_addr,        32'h06);
        lit("mis_cause",  32'(err_cause),  32'h1);
        acc(0, 0, 3'b000, 32'h0, 32'h0, 0);
        lit("mis_pulse_end", 32'(fault), 32'h0);
        acc(1, 0, 3'b001, 32'h33, 32'h0, 0);
        lit("lh33_fault", 32'(fault), 32'h1);
        lit("lh33_addr",  err_addr,   32'h06);
        acc(1, 0, 3'b010, 32'h04, 32'h0, 0);
        lit("word1_kept", ddata_r, 32'h0BADF00D);

        // Out-of-range and clear
        acc(0, 0, 3'b000, 32'h0, 32'h0, 1);
        acc(1, 0, 3'b010, 32'h1000, 32'h0, 0);
        lit("oor_cause", 32'(err_cause), 32'h2);
        lit("oor_addr",  err_addr,       32'h1000);
        lit("oor_hold",  ddata_r,        32'h0BADF00D);
        acc(0, 0, 3'b000, 32'h0, 32'h0, 1);
        lit("clr_sticky", 32'(err_sticky), 32'h0);
        acc(0, 1, 3'b011, 32'h50, 32'h12345678, 1);
        lit("clr_vs_fault_sticky", 32'(err_sticky), 32'h1);
        lit("clr_vs_fault_cause",  32'(err_cause),  32'h3);
        lit("clr_vs_fault_addr",   err_addr,        32'h50);

        // Simultaneous read/write, then back-to-back loads
        acc(1, 1, 3'b010, 32'h40, 32'h00000055, 0);
        lit("rw_hold", ddata_r, 32'h0BADF00D);
        acc(1, 0, 3'b010, 32'h40, 32'h0, 0);
        lit("lw_0x40", ddata_r, 32'h00000055);
        acc(1, 0, 3'b010, 32'h10, 32'h0, 0);
        lit("b2b_0", ddata_r, 32'h1122AB44);
        acc(1, 0, 3'b010, 32'h20, 32'h0, 0);
        lit("b2b_1", ddata_r, 32'h80011234);
        acc(1, 0, 3'b010, 32'h04, 32'h0, 0);
        lit("b2b_2", ddata_r, 32'h0BADF00D);
        acc(0, 0, 3'b000, 32'h0, 32'h0, 0);
        lit("idle_hold", ddata_r, 32'h0BADF00D);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
